// File: rtl/vid_in_axis_v2.sv
// Native parallel video bus to AXI4-Stream video bridge (tuser = SOF, tlast = EOL).
// Ports:
//   aclk, aresetn           : clock, synchronous active-low reset
//   vid_ce, vid_de, vid_*   : qualified native video bus (blanks/syncs are status only)
//   vid_data                : PIXELS_PER_CLK pixels per beat, pixel 0 in the LSBs
//   axis_enable, clr_error  : capture enable, overflow clear pulse
//   m_axis_video_*          : AXI4-Stream master, FWFT FIFO head
//   locked, overflow        : capture status
//   active_width/height     : de beats per line / lines of the last complete frame
//   fifo_level              : current FIFO occupancy
module vid_in_axis_v2 #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PIXELS_PER_CLK = 1,
    parameter int unsigned FIFO_ADDR_BITS = 10,
    parameter int unsigned SIZE_BITS      = 12
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic                                 vid_ce,
    input  logic                                 vid_de,
    input  logic                                 vid_vblank,
    input  logic                                 vid_hblank,
    input  logic                                 vid_vsync,
    input  logic                                 vid_hsync,
    input  logic [DATA_WIDTH*PIXELS_PER_CLK-1:0] vid_data,
    input  logic                                 axis_enable,
    input  logic                                 clr_error,
    output logic [DATA_WIDTH*PIXELS_PER_CLK-1:0] m_axis_video_tdata,
    output logic                                 m_axis_video_tvalid,
    input  logic                                 m_axis_video_tready,
    output logic                                 m_axis_video_tuser,
    output logic                                 m_axis_video_tlast,
    output logic                                 locked,
    output logic                                 overflow,
    output logic [SIZE_BITS-1:0]                 active_width,
    output logic [SIZE_BITS-1:0]                 active_height,
    output logic [FIFO_ADDR_BITS:0]              fifo_level
);

    localparam int unsigned DW    = DATA_WIDTH * PIXELS_PER_CLK;
    localparam int unsigned DEPTH = 1 << FIFO_ADDR_BITS;
    localparam int unsigned LW    = FIFO_ADDR_BITS + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_VB, S_SYNC, S_LOCKED} state_t;

    typedef struct packed {
        logic          sof;
        logic          eol;
        logic [DW-1:0] data;
    } entry_t;

    state_t                    r_state, w_state_nx;
    entry_t                    r_mem [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]             r_count, w_count_nx;
    logic                      r_valid;
    logic                      r_hold_v, r_hold_sof, r_sof_pend;
    logic [DW-1:0]             r_hold_data;
    logic                      r_overflow, r_locked;
    logic                      r_de_d, r_vb_d;
    logic [SIZE_BITS-1:0]      r_beat_cnt, r_line_cnt, r_line_w, r_width, r_height;

    logic   w_push_req, w_push_eol, w_load_hold, w_drop_hold, w_ovf_set, w_sof_arm;
    logic   w_full, w_pop, w_de_fall, w_vb_rise;
    entry_t w_push_word, w_head;
    logic [SIZE_BITS-1:0] w_line_nx, w_line_w_nx;
    logic   w_unused;

    function automatic logic [SIZE_BITS-1:0] sat_inc(input logic [SIZE_BITS-1:0] x);
        return (x == '1) ? x : x + SIZE_BITS'(1);
    endfunction

    assign w_unused    = ^{vid_hblank, vid_vsync, vid_hsync};
    assign w_full      = (r_count == LW'(DEPTH));
    assign w_pop       = r_valid && m_axis_video_tready;
    assign w_push_word = '{sof: r_hold_sof, eol: w_push_eol, data: r_hold_data};
    assign w_count_nx  = r_count + LW'(w_push_req) - LW'(w_pop);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_de_fall   = r_de_d && !vid_de;
    assign w_vb_rise   = vid_vblank && !r_vb_d;
    assign w_line_nx   = w_de_fall ? sat_inc(r_line_cnt) : r_line_cnt;
    assign w_line_w_nx = w_de_fall ? r_beat_cnt : r_line_w;

    // Capture state machine: next state and per-beat push/hold controls.
    always_comb begin
        w_state_nx  = r_state;
        w_push_req  = 1'b0;
        w_push_eol  = 1'b0;
        w_load_hold = 1'b0;
        w_drop_hold = 1'b0;
        w_ovf_set   = 1'b0;
        w_sof_arm   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (vid_ce && axis_enable) w_state_nx = S_WAIT_VB;
            end
            S_WAIT_VB: begin
                if (!axis_enable)              w_state_nx = S_IDLE;
                else if (vid_ce && vid_vblank) w_state_nx = S_SYNC;
            end
            S_SYNC: begin
                if (!axis_enable) begin
                    w_state_nx = S_IDLE;
                end else if (vid_ce && !vid_vblank) begin
                    w_state_nx = S_LOCKED;
                    w_sof_arm  = 1'b1;
                end
            end
            S_LOCKED: begin
                // Disable outside a line stops at once; inside a line it waits for eol.
                if (!axis_enable && !r_hold_v) begin
                    w_state_nx = S_IDLE;
                end else if (vid_ce) begin
                    if (vid_de) begin
                        w_load_hold = 1'b1;
                        w_push_req  = r_hold_v;
                    end else if (r_hold_v) begin
                        w_push_req  = 1'b1;
                        w_push_eol  = 1'b1;
                        w_drop_hold = 1'b1;
                        if (!axis_enable) w_state_nx = S_IDLE;
                    end
                    if (w_push_req && w_full) begin
                        w_push_req  = 1'b0;
                        w_load_hold = 1'b0;
                        w_drop_hold = 1'b1;
                        w_ovf_set   = 1'b1;
                        w_state_nx  = S_WAIT_VB;
                    end
                    if (w_vb_rise) w_sof_arm = 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State, FIFO pointers, hold register, status and measurement.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_hold_v    <= 1'b0;
            r_hold_sof  <= 1'b0;
            r_hold_data <= '0;
            r_sof_pend  <= 1'b0;
            r_overflow  <= 1'b0;
            r_locked    <= 1'b0;
            r_de_d      <= 1'b0;
            r_vb_d      <= 1'b0;
            r_beat_cnt  <= '0;
            r_line_cnt  <= '0;
            r_line_w    <= '0;
            r_width     <= '0;
            r_height    <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_locked <= (w_state_nx == S_LOCKED);
            if (w_push_req) r_wr_ptr <= r_wr_ptr + FIFO_ADDR_BITS'(1);
            if (w_pop)      r_rd_ptr <= r_rd_ptr + FIFO_ADDR_BITS'(1);
            r_count <= w_count_nx;
            r_valid <= (w_count_nx != '0);

            if (w_load_hold) begin
                r_hold_v    <= 1'b1;
                r_hold_data <= vid_data;
                r_hold_sof  <= r_sof_pend;
            end else if (w_drop_hold || (w_state_nx != S_LOCKED)) begin
                r_hold_v <= 1'b0;
            end
            if (w_sof_arm)        r_sof_pend <= 1'b1;
            else if (w_load_hold) r_sof_pend <= 1'b0;

            // A new overflow wins over a simultaneous clear.
            if (w_ovf_set)      r_overflow <= 1'b1;
            else if (clr_error) r_overflow <= 1'b0;

            if (vid_ce) begin
                r_vb_d <= vid_vblank;
                r_de_d <= (r_state == S_LOCKED) && vid_de;
            end

            // Counters only run for frames entered through SYNC.
            if (r_state != S_LOCKED) begin
                r_beat_cnt <= '0;
                r_line_cnt <= '0;
                r_line_w   <= '0;
            end else if (vid_ce) begin
                if (vid_de) r_beat_cnt <= r_de_d ? sat_inc(r_beat_cnt) : SIZE_BITS'(1);
                if (w_vb_rise) begin
                    r_width    <= w_line_w_nx;
                    r_height   <= w_line_nx;
                    r_line_cnt <= '0;
                    r_line_w   <= '0;
                end else begin
                    r_line_cnt <= w_line_nx;
                    r_line_w   <= w_line_w_nx;
                end
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge aclk) begin
        if (w_push_req) r_mem[r_wr_ptr] <= w_push_word;
    end

    assign m_axis_video_tvalid = r_valid;
    assign m_axis_video_tdata  = r_valid ? w_head.data : '0;
    assign m_axis_video_tuser  = r_valid && w_head.sof;
    assign m_axis_video_tlast  = r_valid && w_head.eol;
    assign locked              = r_locked;
    assign overflow            = r_overflow;
    assign active_width        = r_width;
    assign active_height       = r_height;
    assign fifo_level          = r_count;

endmodule

// File: tb/tb_vid_in_axis_v2.sv
// Directed bench for vid_in_axis_v2 (2 pixels/beat, 4-entry FIFO).
module tb_vid_in_axis_v2;

    localparam int unsigned DW  = 8;
    localparam int unsigned PPC = 2;
    localparam int unsigned FAB = 2;
    localparam int unsigned SB  = 12;

    logic                 aclk = 1'b0;
    logic                 aresetn, vid_ce, vid_de, vid_vblank, vid_hblank, vid_vsync, vid_hsync;
    logic [DW*PPC-1:0]    vid_data;
    logic                 axis_enable, clr_error, tready;
    logic [DW*PPC-1:0]    tdata;
    logic                 tvalid, tuser, tlast, locked, overflow;
    logic [SB-1:0]        active_width, active_height;
    logic [FAB:0]         fifo_level;

    int checks = 0;
    int errors = 0;
    int gap = 1;
    int pix = 0;
    logic rnd_rdy = 1'b0;
    logic stall_prev = 1'b0;
    logic [17:0] got [$];
    logic [17:0] exp_q [$];

    always #5 aclk = ~aclk;

    vid_in_axis_v2 #(
        .DATA_WIDTH(DW), .PIXELS_PER_CLK(PPC), .FIFO_ADDR_BITS(FAB), .SIZE_BITS(SB)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .vid_ce(vid_ce), .vid_de(vid_de),
        .vid_vblank(vid_vblank), .vid_hblank(vid_hblank), .vid_vsync(vid_vsync),
        .vid_hsync(vid_hsync), .vid_data(vid_data), .axis_enable(axis_enable),
        .clr_error(clr_error), .m_axis_video_tdata(tdata), .m_axis_video_tvalid(tvalid),
        .m_axis_video_tready(tready), .m_axis_video_tuser(tuser), .m_axis_video_tlast(tlast),
        .locked(locked), .overflow(overflow), .active_width(active_width),
        .active_height(active_height), .fifo_level(fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Collect handshakes and check that a stalled beat is never withdrawn.
    always @(negedge aclk) begin
        if (aresetn === 1'b1) begin
            if (stall_prev) chk("tvalid held under stall", 32'(tvalid), 32'd1);
            if (tvalid && tready) got.push_back({tuser, tlast, tdata});
            stall_prev = tvalid && !tready;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        // Forcing ready near full keeps the random-ready stream loss-free.
        if (rnd_rdy) tready = (fifo_level >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge aclk);
        #1;
    endtask

    task automatic beat(input logic de, input logic vb, input logic rec,
                        input logic sof, input logic eol);
        for (int g = 1; g < gap; g++) begin
            vid_ce = 1'b0;
            cyc();
        end
        vid_ce = 1'b1; vid_de = de; vid_vblank = vb; vid_vsync = vb;
        vid_hblank = !de && !vb;
        if (de) begin
            vid_data = {8'(pix * 2 + 1), 8'(pix * 2)};
            if (rec) exp_q.push_back({sof, eol, vid_data});
            pix++;
        end
        cyc();
        vid_ce = 1'b0;
    endtask

    task automatic blank(input int n, input logic vb);
        for (int i = 0; i < n; i++) beat(1'b0, vb, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic line(input int n, input logic rec, input logic sof_first, input int drop_at);
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) axis_enable = 1'b0;
            beat(1'b1, 1'b0, rec, sof_first && (i == 0), i == n - 1);
        end
        blank(3, 1'b0);
    endtask

    task automatic frame(input int nl, input int nb, input logic rec);
        blank(2, 1'b0);
        for (int l = 0; l < nl; l++) line(nb, rec, l == 0, -1);
        blank(3, 1'b1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (tvalid && n < 300) begin
            cyc();
            n++;
        end
        if (n >= 300) chk({tag, " drain timeout"}, 32'(n), 32'd0);
        cyc();
        cyc();
    endtask

    task automatic cmp(input string tag);
        chk({tag, " beat count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s beat%0d {tuser,tlast,tdata}", tag, i), 32'(got[i]), 32'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        aresetn = 1'b0; vid_ce = 1'b0; vid_de = 1'b0; vid_vblank = 1'b0; vid_hblank = 1'b0;
        vid_vsync = 1'b0; vid_hsync = 1'b0; vid_data = '0; axis_enable = 1'b0;
        clr_error = 1'b0; tready = 1'b1;
        cyc();
        cyc();
        chk("reset tvalid", 32'(tvalid), 32'd0);
        chk("reset tuser/tlast", 32'({tuser, tlast}), 32'd0);
        chk("reset tdata", 32'(tdata), 32'd0);
        chk("reset locked", 32'(locked), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset fifo_level", 32'(fifo_level), 32'd0);
        chk("reset size", 32'({active_width, active_height}), 32'd0);
        aresetn = 1'b1;

        // Basic 4x3 frame.
        axis_enable = 1'b1;
        blank(3, 1'b1);
        frame(3, 4, 1'b1);
        drain("frame4x3");
        cmp("frame4x3");
        chk("frame4x3 width", 32'(active_width), 32'd4);
        chk("frame4x3 height", 32'(active_height), 32'd3);
        chk("frame4x3 locked", 32'(locked), 32'd1);

        // Enable dropped mid-line: line completes, then idle.
        blank(2, 1'b0);
        line(4, 1'b1, 1'b1, 2);
        chk("disable locked", 32'(locked), 32'd0);
        line(4, 1'b0, 1'b0, -1);
        blank(3, 1'b1);
        drain("disable");
        cmp("disable");
        chk("disable width kept", 32'(active_width), 32'd4);
        chk("disable height kept", 32'(active_height), 32'd3);

        // Enable asserted mid-frame.
        axis_enable = 1'b1;
        line(4, 1'b0, 1'b0, -1);
        chk("midframe fifo_level", 32'(fifo_level), 32'd0);
        cmp("midframe no output");
        blank(3, 1'b1);
        chk("midframe width not latched", 32'(active_width), 32'd4);
        chk("midframe height not latched", 32'(active_height), 32'd3);
        frame(2, 3, 1'b1);
        drain("midframe");
        cmp("midframe");
        chk("midframe width", 32'(active_width), 32'd3);
        chk("midframe height", 32'(active_height), 32'd2);

        // Overflow with tready held low on an 8-beat line.
        tready = 1'b0;
        blank(2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, 1'b0, i < 4, i == 0, 1'b0);
            if (i == 4) begin
                chk("ovf before 5th push overflow", 32'(overflow), 32'd0);
                chk("ovf before 5th push level", 32'(fifo_level), 32'd4);
            end
            if (i == 5) begin
                chk("ovf 5th push overflow", 32'(overflow), 32'd1);
                chk("ovf 5th push locked", 32'(locked), 32'd0);
            end
        end
        blank(3, 1'b0);
        chk("ovf stalled tvalid", 32'(tvalid), 32'd1);
        tready = 1'b1;
        drain("ovf drain");
        cmp("ovf drain");
        blank(3, 1'b1);
        frame(1, 2, 1'b1);
        drain("ovf next frame");
        cmp("ovf next frame");
        chk("ovf sticky", 32'(overflow), 32'd1);
        clr_error = 1'b1;
        cyc();
        clr_error = 1'b0;
        chk("ovf cleared", 32'(overflow), 32'd0);

        // vid_ce every 3rd cycle, random ready.
        gap = 3;
        rnd_rdy = 1'b1;
        frame(3, 5, 1'b1);
        drain("ce3 random");
        rnd_rdy = 1'b0;
        tready = 1'b1;
        gap = 1;
        cmp("ce3 random");
        chk("ce3 width", 32'(active_width), 32'd5);
        chk("ce3 height", 32'(active_height), 32'd3);

        // One-cycle reset mid-frame with entries queued.
        tready = 1'b0;
        blank(2, 1'b0);
        for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst queued level", 32'(fifo_level), 32'd2);
        aresetn = 1'b0;
        cyc();
        chk("rst tvalid", 32'(tvalid), 32'd0);
        chk("rst fifo_level", 32'(fifo_level), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        chk("rst locked", 32'(locked), 32'd0);
        aresetn = 1'b1;
        tready = 1'b1;
        for (int i = 0; i < 2; i++) beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        blank(3, 1'b0);
        line(3, 1'b0, 1'b0, -1);
        drain("rst pre-vblank");
        cmp("rst no relock before vblank");
        blank(3, 1'b1);
        frame(1, 2, 1'b1);
        drain("rst relock");
        cmp("rst relock");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
